heap_cmd_sequencer: RTL and testbench
=====================================

Name: heap_cmd_sequencer

Overview:
- Upstream command front-end for heap_control.
- Accepts push/pop commands on a valid/ready stream and buffers them in a small FIFO.
- Issues each command to heap_control as a one-cycle start pulse, waits for done, and returns pop results on a valid/ready result stream.
- Guards the heap against overflow, underflow and illegal opcodes; a watchdog flags a hung heap.

Parameters:
- DATA_W, 32, key/result width
- N_W, 10, width of heap element count
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- HEAP_CAP, 1023, max elements; push refused when hp_n >= HEAP_CAP
- TIMEOUT, 4096, max cycles spent in WAIT before abort

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_op  in  2  00 nop, 01 push, 10 pop, 11 illegal
- cmd_key  in  DATA_W  key for push (ignored otherwise)
- hp_start  out  1  start pulse to heap_control
- hp_instruction  out  2  opcode to heap_control
- hp_key  out  DATA_W  key to heap_control
- hp_done  in  1  heap_control operation complete
- hp_arr_out  in  DATA_W  heap_control popped value
- hp_n  in  N_W  heap_control element count
- res_valid  out  1  pop result valid
- res_ready  in  1  result consumer ready
- res_data  out  DATA_W  popped value
- err_pulse  out  1  one-cycle error strobe
- err_code  out  2  00 timeout, 01 overflow, 10 underflow, 11 illegal
- busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset (synchronous, active-high, clk): FIFO flushed; state IDLE. Outputs reset to:
  - cmd_ready=1, hp_start=0, hp_instruction=00, hp_key=0
  - res_valid=0, res_data=0, err_pulse=0, err_code=00, busy=0
- Reset mid-operation aborts everything: no result, no error. heap_control shares the reset.
- FIFO write occurs on cmd_valid && cmd_ready.
  - cmd_ready depends only on full, so a same-cycle dequeue does not free a slot.
  - Read and write in the same cycle are both honoured.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESULT.
- IDLE with FIFO non-empty: dequeue head and evaluate it against hp_n as sampled that cycle.
  - op 00: drop silently, stay IDLE.
  - op 11: err_pulse=1, err_code=11 next cycle; stay IDLE.
  - op 01 with hp_n >= HEAP_CAP: err code 01, dropped.
  - op 10 with hp_n == 0: err code 10, dropped.
  - Otherwise latch op/key into hp_instruction/hp_key and go to ISSUE.
  - At most one command is dequeued per IDLE cycle.
- ISSUE (exactly 1 cycle): hp_start=1; next state WAIT. hp_instruction/hp_key are held stable from ISSUE through the end of WAIT.
- WAIT: hp_start=0; timeout counter increments each cycle.
  - hp_done=1 with push: go to IDLE.
  - hp_done=1 with pop: capture hp_arr_out into res_data, set res_valid=1, go to RESULT.
  - Counter reaches TIMEOUT-1 without done: err_pulse, code 00; go to IDLE and drop the command.
  - hp_done is ignored in every state except WAIT.
- RESULT: hold res_valid/res_data until res_ready=1. On that cycle the transfer completes, res_valid clears next cycle, and the state returns to IDLE. No new command is issued while a result is pending.
- Command-to-start latency: a command written at cycle t into an empty FIFO with state IDLE is dequeued at t+1, and hp_start is high at t+2.
- err_pulse is high for exactly one cycle per error. err_code holds its last value.
- Pointer wrap: FIFO pointers carry an extra MSB for full/empty detection. After DEPTH writes without a read, full=1 and cmd_ready=0.

Test Plan:
- Reset, then push key 0x0000002A with heap model hp_n=0 and done returned 3 cycles after start -> hp_start high for one cycle with hp_instruction=01, hp_key=0x2A; no res_valid; busy drops after done.
- Pop with hp_n=1, model returns hp_arr_out=0x2A on done, res_ready=0 for 5 cycles then 1 -> res_valid=1, res_data=0x2A held stable for all 6 cycles, then clears; next command issues only after the transfer.
- Pop with hp_n=0 -> err_pulse one cycle, err_code=10, hp_start never asserted. Push with hp_n=1023 -> err_code=01. Op 11 -> err_code=11.
- Stall heap (no done), 5 back-to-back pushes with DEPTH=4 -> first dequeued, next 4 fill the FIFO, cmd_ready=0. After TIMEOUT=16 cycles in WAIT -> err_code=00, then the next push issues.
- Reset asserted during WAIT with a pop pending and FIFO holding 2 entries -> next cycle state IDLE, busy=0, res_valid=0, cmd_ready=1, no err_pulse, no further hp_start.
- Stream ops 00, 01(key 7), 10 with a responsive model -> nop consumed with no start; push start then pop start; result res_data equals the model value.

Source files
------------

// File: rtl/heap_cmd_sequencer.sv
// Command front-end for heap_control: buffers push/pop commands, screens them
// against the heap occupancy, sequences start/done and returns pop results.
module heap_cmd_sequencer #(
    parameter int DATA_W   = 32,
    parameter int N_W      = 10,
    parameter int DEPTH    = 4,
    parameter int HEAP_CAP = 1023,
    parameter int TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_key,
    output logic              hp_start,
    output logic [1:0]        hp_instruction,
    output logic [DATA_W-1:0] hp_key,
    input  logic              hp_done,
    input  logic [DATA_W-1:0] hp_arr_out,
    input  logic [N_W-1:0]    hp_n,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              err_pulse,
    output logic [1:0]        err_code,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [N_W-1:0] CAP      = N_W'(HEAP_CAP);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_e;
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_ILL  = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        ERR_TIMEOUT   = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_ILLEGAL   = 2'b11
    } err_e;

    state_e state_q, state_d;

    logic [DATA_W+1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              wr_en, rd_en, empty, empty_d, full_d;

    logic              hp_start_q, hp_start_d;
    op_e               hp_instruction_q, hp_instruction_d;
    logic [DATA_W-1:0] hp_key_q, hp_key_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              err_pulse_q, err_pulse_d;
    err_e              err_code_q, err_code_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [DATA_W+1:0] head;
    op_e               head_op;
    logic [DATA_W-1:0] head_key;
    logic              issue, screen_err, timeout_hit;
    err_e              screen_code;

    // FIFO bookkeeping; pointers carry an extra wrap bit for full/empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign wr_en = cmd_valid && cmd_ready_q;
    assign rd_en = (state_q == IDLE) && !empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(wr_en);
        rd_ptr_d    = rd_ptr_q + PW'(rd_en);
        empty_d     = (wr_ptr_d == rd_ptr_d);
        full_d      = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        cmd_ready_d = !full_d;
        busy_d      = !empty_d || (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_key};
        end
    end

    // Screening of the dequeued head against the occupancy seen this cycle.
    always_comb begin
        head_op     = op_e'(head[DATA_W+1:DATA_W]);
        head_key    = head[DATA_W-1:0];
        issue       = 1'b0;
        screen_err  = 1'b0;
        screen_code = ERR_ILLEGAL;
        if (rd_en) begin
            case (head_op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (hp_n >= CAP) begin
                        screen_err  = 1'b1;
                        screen_code = ERR_OVERFLOW;
                    end else begin
                        issue = 1'b1;
                    end
                end
                OP_POP: begin
                    if (hp_n == '0) begin
                        screen_err  = 1'b1;
                        screen_code = ERR_UNDERFLOW;
                    end else begin
                        issue = 1'b1;
                    end
                end
                default: begin
                    screen_err  = 1'b1;
                    screen_code = ERR_ILLEGAL;
                end
            endcase
        end
    end

    assign timeout_hit = (state_q == WAIT) && !hp_done && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (issue) state_d = ISSUE;
            ISSUE:  state_d = WAIT;
            WAIT: begin
                if (hp_done) begin
                    state_d = (hp_instruction_q == OP_POP) ? RESULT : IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            RESULT: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hp_start_d       = (state_d == ISSUE);
        hp_instruction_d = hp_instruction_q;
        hp_key_d         = hp_key_q;
        res_valid_d      = res_valid_q;
        res_data_d       = res_data_q;
        err_pulse_d      = 1'b0;
        err_code_d       = err_code_q;
        cnt_d            = cnt_q;
        if (issue) begin
            hp_instruction_d = head_op;
            hp_key_d         = head_key;
        end
        if (screen_err) begin
            err_pulse_d = 1'b1;
            err_code_d  = screen_code;
        end
        case (state_q)
            ISSUE: cnt_d = '0;
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (hp_done) begin
                    if (hp_instruction_q == OP_POP) begin
                        res_valid_d = 1'b1;
                        res_data_d  = hp_arr_out;
                    end
                end else if (timeout_hit) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            RESULT: if (res_ready) res_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cmd_ready_q      <= 1'b1;
            busy_q           <= 1'b0;
            hp_start_q       <= 1'b0;
            hp_instruction_q <= OP_NOP;
            hp_key_q         <= '0;
            res_valid_q      <= 1'b0;
            res_data_q       <= '0;
            err_pulse_q      <= 1'b0;
            err_code_q       <= ERR_TIMEOUT;
            cnt_q            <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cmd_ready_q      <= cmd_ready_d;
            busy_q           <= busy_d;
            hp_start_q       <= hp_start_d;
            hp_instruction_q <= hp_instruction_d;
            hp_key_q         <= hp_key_d;
            res_valid_q      <= res_valid_d;
            res_data_q       <= res_data_d;
            err_pulse_q      <= err_pulse_d;
            err_code_q       <= err_code_d;
            cnt_q            <= cnt_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign hp_start       = hp_start_q;
    assign hp_instruction = hp_instruction_q;
    assign hp_key         = hp_key_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign err_pulse      = err_pulse_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_heap_cmd_sequencer.sv
// Bench for heap_cmd_sequencer: a small heap_control model answers starts,
// expected starts/errors/results are queued at drive time and popped on output.
module tb_heap_cmd_sequencer;
    localparam int DW = 32;
    localparam int NW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_key;
    logic          hp_start;
    logic [1:0]    hp_instruction;
    logic [DW-1:0] hp_key;
    logic          hp_done;
    logic [DW-1:0] hp_arr_out;
    logic [NW-1:0] hp_n;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic          busy;

    always #5 clk = ~clk;

    heap_cmd_sequencer #(
        .DATA_W(DW), .N_W(NW), .DEPTH(4), .HEAP_CAP(1023), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
        .hp_start(hp_start), .hp_instruction(hp_instruction), .hp_key(hp_key),
        .hp_done(hp_done), .hp_arr_out(hp_arr_out), .hp_n(hp_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cnt = 0, err_cnt = 0, res_cnt = 0;
    int start_cyc = 0, err_cyc = 0;
    logic [DW+1:0] start_log[$], exp_start_q[$];
    logic [1:0]    err_log[$], exp_err_q[$];
    logic [DW-1:0] exp_res_q[$];

    logic          model_stall = 1'b0;
    int            model_delay = 3;
    logic [DW-1:0] model_value = '0;
    int            mdl_cnt;
    logic          mdl_busy;

    always @(posedge clk) cyc <= cyc + 1;

    // heap_control stand-in: done arrives model_delay cycles after start is seen
    always @(posedge clk) begin
        hp_done <= 1'b0;
        if (reset) begin
            mdl_busy   <= 1'b0;
            mdl_cnt    <= 0;
            hp_arr_out <= '0;
        end else if (mdl_busy) begin
            if (mdl_cnt <= 1) begin
                hp_done    <= 1'b1;
                hp_arr_out <= model_value;
                mdl_busy   <= 1'b0;
            end
            mdl_cnt <= mdl_cnt - 1;
        end else if (hp_start && !model_stall) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= model_delay;
        end
    end

    always @(negedge clk) begin
        if (hp_start) begin
            start_cnt++;
            start_log.push_back({hp_instruction, hp_key});
            start_cyc = cyc;
        end
        if (err_pulse) begin
            err_cnt++;
            err_log.push_back(err_code);
            err_cyc = cyc;
        end
        if (res_valid) res_cnt++;
    end

    // Called aligned just after a posedge; returns just after the accepting posedge.
    task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] key);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_cmd_ready_wait cmd_ready=%b required=1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || res_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || res_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_idle_wait busy=%b res_valid=%b required=0", tag, busy, res_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        vectors++;
        if ({hp_start, hp_instruction, hp_key, res_valid, res_data, err_pulse, err_code} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got start=%b ins=%b key=%h rv=%b rd=%h ep=%b ec=%b exp all zero",
                     hp_start, hp_instruction, hp_key, res_valid, res_data, err_pulse, err_code);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_push();
        int s0, r0;
        logic [DW+1:0] e, g;
        s0 = start_cnt;
        r0 = res_cnt;
        hp_n = 0;
        model_delay = 3;
        exp_start_q.push_back({2'b01, 32'h2A});
        send_cmd(2'b01, 32'h2A);
        @(negedge clk);
        vectors++;
        if (hp_start !== 1'b0) begin
            miscompares++;
            $display("FAIL push_start_early got=%b exp=0", hp_start);
        end
        @(negedge clk);
        vectors++;
        if ({hp_start, hp_instruction, hp_key} !== {1'b1, 2'b01, 32'h2A}) begin
            miscompares++;
            $display("FAIL push_start_latency got=%b/%b/%h exp=1/01/0000002a", hp_start, hp_instruction, hp_key);
        end
        @(negedge clk);
        vectors++;
        if ({hp_start, hp_instruction, hp_key} !== {1'b0, 2'b01, 32'h2A}) begin
            miscompares++;
            $display("FAIL push_start_width got=%b/%b/%h exp=0/01/0000002a", hp_start, hp_instruction, hp_key);
        end
        wait_idle("push");
        vectors++;
        if (start_cnt - s0 != 1 || res_cnt != r0) begin
            miscompares++;
            $display("FAIL push_counts starts=%0d results=%0d exp=1,0", start_cnt - s0, res_cnt - r0);
        end
        while (exp_start_q.size() != 0) begin
            e = exp_start_q.pop_front();
            if (start_log.size() != 0) g = start_log.pop_front();
            else g = 'x;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL push_start_cmd got=%h exp=%h", g, e);
            end
        end
        start_log.delete();
    endtask

    task automatic test_pop_result();
        int n, s0;
        logic [DW-1:0] exp_d;
        logic [DW+1:0] e, g;
        n = 0;
        s0 = start_cnt;
        hp_n = 1;
        model_delay = 3;
        model_value = 32'h2A;
        res_ready = 1'b0;
        exp_start_q.push_back({2'b10, 32'h0});
        exp_start_q.push_back({2'b01, 32'h55});
        exp_res_q.push_back(32'h2A);
        send_cmd(2'b10, 32'h0);
        send_cmd(2'b01, 32'h55);
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL pop_result_wait res_valid=%b required=1", res_valid);
        end
        exp_d = exp_res_q.pop_front();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (res_valid !== 1'b1 || res_data !== exp_d) begin
                miscompares++;
                $display("FAIL pop_result_hold cycle=%0d got=%b/%h exp=1/%h", i, res_valid, res_data, exp_d);
            end
            vectors++;
            if (hp_start !== 1'b0) begin
                miscompares++;
                $display("FAIL pop_issue_while_pending cycle=%0d got=%b exp=0", i, hp_start);
            end
            if (i == 5) res_ready = 1'b1;
            @(posedge clk);
            #1;
            if (i < 5) @(negedge clk);
        end
        res_ready = 1'b0;
        vectors++;
        if (start_cnt - s0 != 1) begin
            miscompares++;
            $display("FAIL pop_starts_before_transfer got=%0d exp=1", start_cnt - s0);
        end
        @(negedge clk);
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_result_clear got=%b exp=0", res_valid);
        end
        res_ready = 1'b1;
        wait_idle("pop");
        while (exp_start_q.size() != 0) begin
            e = exp_start_q.pop_front();
            if (start_log.size() != 0) g = start_log.pop_front();
            else g = 'x;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL pop_start_cmd got=%h exp=%h", g, e);
            end
        end
        start_log.delete();
    endtask

    task automatic test_errors();
        int s0, e0;
        logic [1:0] e, g;
        s0 = start_cnt;
        e0 = err_cnt;
        hp_n = 0;
        exp_err_q.push_back(2'b10);
        send_cmd(2'b10, 32'h0);
        wait_idle("underflow");
        hp_n = 1023;
        exp_err_q.push_back(2'b01);
        send_cmd(2'b01, 32'h9);
        wait_idle("overflow");
        exp_err_q.push_back(2'b11);
        send_cmd(2'b11, 32'h0);
        wait_idle("illegal");
        @(negedge clk);
        vectors++;
        if (err_pulse !== 1'b0 || err_code !== 2'b11) begin
            miscompares++;
            $display("FAIL err_code_hold got=%b/%b exp=0/11", err_pulse, err_code);
        end
        #1;
        vectors++;
        if (err_cnt - e0 != 3 || start_cnt != s0) begin
            miscompares++;
            $display("FAIL err_counts pulse_cycles=%0d starts=%0d exp=3,0", err_cnt - e0, start_cnt - s0);
        end
        while (exp_err_q.size() != 0) begin
            e = exp_err_q.pop_front();
            if (err_log.size() != 0) g = err_log.pop_front();
            else g = 'x;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL err_code got=%b exp=%b", g, e);
            end
        end
        err_log.delete();
        // one below capacity is still accepted
        @(posedge clk);
        #1;
        hp_n = 1022;
        s0 = start_cnt;
        send_cmd(2'b01, 32'h3FE);
        wait_idle("cap_minus_one");
        vectors++;
        if (start_cnt - s0 != 1 || err_cnt - e0 != 3) begin
            miscompares++;
            $display("FAIL cap_minus_one starts=%0d errs=%0d exp=1,3", start_cnt - s0, err_cnt - e0);
        end
        start_log.delete();
    endtask

    task automatic test_timeout();
        int s0, e0, n, t_start, t_err;
        logic [DW+1:0] e, g;
        n = 0;
        t_err = 0;
        hp_n = 0;
        model_stall = 1'b1;
        model_delay = 3;
        s0 = start_cnt;
        e0 = err_cnt;
        for (int i = 1; i <= 5; i++) begin
            exp_start_q.push_back({2'b01, 32'(i)});
            send_cmd(2'b01, 32'(i));
        end
        exp_err_q.push_back(2'b00);
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fifo_full got ready=%b busy=%b exp=0,1", cmd_ready, busy);
        end
        #1;
        vectors++;
        if (start_cnt - s0 != 1) begin
            miscompares++;
            $display("FAIL stall_starts got=%0d exp=1", start_cnt - s0);
        end
        t_start = start_cyc;
        @(negedge clk);
        while (!err_pulse && n < 60) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (err_pulse !== 1'b1 || err_code !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_err got=%b/%b exp=1/00", err_pulse, err_code);
        end
        model_stall = 1'b0;
        #1;
        t_err = err_cyc;
        vectors++;
        if (t_err - t_start != TO + 1) begin
            miscompares++;
            $display("FAIL timeout_latency got=%0d exp=%0d", t_err - t_start, TO + 1);
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || hp_start !== 1'b1 || hp_key !== 32'h2) begin
            miscompares++;
            $display("FAIL after_timeout_issue got ready=%b start=%b key=%h exp=1,1,00000002", cmd_ready, hp_start, hp_key);
        end
        wait_idle("timeout");
        vectors++;
        if (err_cnt - e0 != 1) begin
            miscompares++;
            $display("FAIL timeout_err_count got=%0d exp=1", err_cnt - e0);
        end
        while (exp_err_q.size() != 0) begin
            vectors++;
            if (err_log.size() == 0 || err_log[0] !== exp_err_q[0]) begin
                miscompares++;
                $display("FAIL timeout_code logged=%0d exp=%b", err_log.size(), exp_err_q[0]);
            end
            void'(exp_err_q.pop_front());
            if (err_log.size() != 0) void'(err_log.pop_front());
        end
        err_log.delete();
        while (exp_start_q.size() != 0) begin
            e = exp_start_q.pop_front();
            if (start_log.size() != 0) g = start_log.pop_front();
            else g = 'x;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL timeout_start_cmd got=%h exp=%h", g, e);
            end
        end
        start_log.delete();
    endtask

    task automatic test_reset_mid_wait();
        int s0, e0, r0;
        hp_n = 1;
        model_stall = 1'b1;
        r0 = res_cnt;
        send_cmd(2'b10, 32'h0);
        send_cmd(2'b01, 32'h11);
        send_cmd(2'b01, 32'h22);
        s0 = start_cnt;
        e0 = err_cnt;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || cmd_ready !== 1'b1 || hp_instruction !== 2'b10) begin
            miscompares++;
            $display("FAIL pre_reset got busy=%b ready=%b ins=%b exp=1,1,10", busy, cmd_ready, hp_instruction);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_stall = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, res_valid, cmd_ready, err_pulse, hp_start} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_mid_wait got busy=%b rv=%b ready=%b ep=%b st=%b exp=0,0,1,0,0",
                     busy, res_valid, cmd_ready, err_pulse, hp_start);
        end
        repeat (TO + 10) @(posedge clk);
        #1;
        vectors++;
        if (start_cnt != s0 || err_cnt != e0 || res_cnt != r0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet starts=%0d errs=%0d results=%0d exp=0,0,0",
                     start_cnt - s0, err_cnt - e0, res_cnt - r0);
        end
        start_log.delete();
        err_log.delete();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [DW+1:0] e, g;
        logic [DW-1:0] exp_d;
        n = 0;
        hp_n = 1;
        model_delay = 2;
        model_value = 32'h77;
        res_ready = 1'b1;
        exp_start_q.push_back({2'b01, 32'h7});
        exp_start_q.push_back({2'b10, 32'h0});
        exp_res_q.push_back(32'h77);
        send_cmd(2'b00, 32'h0);
        send_cmd(2'b01, 32'h7);
        send_cmd(2'b10, 32'h0);
        @(negedge clk);
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp_d = exp_res_q.pop_front();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== exp_d) begin
            miscompares++;
            $display("FAIL stream_result got=%b/%h exp=1/%h", res_valid, res_data, exp_d);
        end
        wait_idle("stream");
        while (exp_start_q.size() != 0) begin
            e = exp_start_q.pop_front();
            if (start_log.size() != 0) g = start_log.pop_front();
            else g = 'x;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL stream_start_cmd got=%h exp=%h", g, e);
            end
        end
        vectors++;
        if (start_log.size() != 0) begin
            miscompares++;
            $display("FAIL stream_extra_starts got=%0d exp=0", start_log.size());
        end
        start_log.delete();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_key   = '0;
        hp_n      = '0;
        res_ready = 1'b1;
        test_reset();
        test_push();
        test_pop_result();
        test_errors();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit reached required=finish");
        $fatal(1);
    end

endmodule
